// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC: one angle in, unscaled (1/K)*(cos, sin) out
// in sign-magnitude form for the downstream gain-scaling stage.
module cordic_rotator #(
  parameter int DATA_WIDTH = 20,
  parameter int FRAC_WIDTH = 12,
  parameter int ITER       = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rst_step,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] angle_in,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [DATA_WIDTH-1:0] y_out,
  output logic                  new_data,
  output logic                  range_err
);

  localparam int IW = DATA_WIDTH + 2;
  localparam logic signed [IW-1:0] PI       = IW'(32'sd12868);
  localparam logic signed [IW-1:0] HALF_PI  = IW'(32'sd6434);
  localparam logic signed [IW-1:0] ONE      = IW'(32'sd1) <<< FRAC_WIDTH;
  localparam logic [3:0]           CNT_LAST = 4'(ITER - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ROT, CONV, DONE} state_t;

  function automatic logic signed [IW-1:0] atan_lut(input logic [3:0] idx);
    logic [11:0] v;
    case (idx)
      4'd0:    v = 12'd3217;
      4'd1:    v = 12'd1899;
      4'd2:    v = 12'd1003;
      4'd3:    v = 12'd509;
      4'd4:    v = 12'd256;
      4'd5:    v = 12'd128;
      4'd6:    v = 12'd64;
      4'd7:    v = 12'd32;
      4'd8:    v = 12'd16;
      4'd9:    v = 12'd8;
      4'd10:   v = 12'd4;
      4'd11:   v = 12'd2;
      default: v = 12'd0;
    endcase
    return {{(IW-12){1'b0}}, v};
  endfunction

  // Two's complement to sign-magnitude; saturates, and zero always gets sign 0.
  function automatic logic [DATA_WIDTH-1:0] to_sm(input logic signed [IW-1:0] v);
    logic [IW-1:0]         mag;
    logic [DATA_WIDTH-1:0] res;
    mag = v[IW-1] ? IW'(-v) : IW'(v);
    if (mag[IW-1:DATA_WIDTH-1] != '0) begin
      res = {v[IW-1], {(DATA_WIDTH-1){1'b1}}};
    end else begin
      res = {v[IW-1], mag[DATA_WIDTH-2:0]};
    end
    return res;
  endfunction

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   angle_q, angle_d;
  logic signed [IW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    flip_q, flip_d;
  logic                    rerr_int_q, rerr_int_d;
  logic                    busy_q, busy_d;
  logic                    new_data_q, new_data_d;
  logic                    range_err_q, range_err_d;
  logic [DATA_WIDTH-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
  logic signed [IW-1:0]    ang_ext_s, xf_s, yf_s;

  assign ang_ext_s = {{2{angle_q[DATA_WIDTH-1]}}, angle_q};

  always_comb begin
    state_d     = state_q;
    angle_d     = angle_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    flip_d      = flip_q;
    rerr_int_d  = rerr_int_q;
    busy_d      = busy_q;
    new_data_d  = 1'b0;
    range_err_d = range_err_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    xf_s        = flip_q ? -x_q : x_q;
    yf_s        = flip_q ? -y_q : y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          angle_d = angle_in;
          busy_d  = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        // Fold into the CORDIC convergence range; the half-turn is undone in CONV.
        if (ang_ext_s > HALF_PI) begin
          z_d    = ang_ext_s - PI;
          flip_d = 1'b1;
        end else if (ang_ext_s < -HALF_PI) begin
          z_d    = ang_ext_s + PI;
          flip_d = 1'b1;
        end else begin
          z_d    = ang_ext_s;
          flip_d = 1'b0;
        end
        x_d        = ONE;
        y_d        = '0;
        cnt_d      = 4'd0;
        rerr_int_d = (ang_ext_s > PI) || (ang_ext_s < -PI);
        state_d    = ROT;
      end
      ROT: begin
        if (!z_q[IW-1]) begin
          x_d = x_q - (y_q >>> cnt_q);
          y_d = y_q + (x_q >>> cnt_q);
          z_d = z_q - atan_lut(cnt_q);
        end else begin
          x_d = x_q + (y_q >>> cnt_q);
          y_d = y_q - (x_q >>> cnt_q);
          z_d = z_q + atan_lut(cnt_q);
        end
        if (cnt_q == CNT_LAST) begin
          state_d = CONV;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      CONV: begin
        x_out_d     = to_sm(xf_s);
        y_out_d     = to_sm(yf_s);
        range_err_d = rerr_int_q;
        new_data_d  = 1'b1;
        busy_d      = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        if (start) begin
          angle_d = angle_in;
          busy_d  = 1'b1;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst or posedge rst_step) begin
    if (rst || rst_step) begin
      state_q     <= IDLE;
      angle_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= 4'd0;
      flip_q      <= 1'b0;
      rerr_int_q  <= 1'b0;
      busy_q      <= 1'b0;
      new_data_q  <= 1'b0;
      range_err_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      angle_q     <= angle_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      cnt_q       <= cnt_d;
      flip_q      <= flip_d;
      rerr_int_q  <= rerr_int_d;
      busy_q      <= busy_d;
      new_data_q  <= new_data_d;
      range_err_q <= range_err_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
    end
  end

  assign busy      = busy_q;
  assign new_data  = new_data_q;
  assign range_err = range_err_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;

endmodule

// File: tb/tb_cordic_rotator.sv
// Self-checking bench for cordic_rotator: directed cases plus random angles
// compared against an integer algorithm model and real-valued trig.
module tb_cordic_rotator;

  localparam int DW   = 20;
  localparam int ITER = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rst_step = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] angle_in = '0;
  logic          busy, new_data, range_err;
  logic [DW-1:0] x_out, y_out;

  int total = 0;
  int bad   = 0;

  cordic_rotator dut (
    .clk(clk), .rst(rst), .rst_step(rst_step), .start(start), .angle_in(angle_in),
    .busy(busy), .x_out(x_out), .y_out(y_out), .new_data(new_data), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sm_of(input int v);
    int mag;
    logic [DW-1:0] r;
    mag = (v < 0) ? -v : v;
    if (mag > (2**(DW-1) - 1)) mag = 2**(DW-1) - 1;
    r = DW'(mag);
    r[DW-1] = (v < 0);
    return r;
  endfunction

  function automatic int int_of_sm(input logic [DW-1:0] s);
    int mag;
    mag = int'(s[DW-2:0]);
    return s[DW-1] ? -mag : mag;
  endfunction

  // Integer rendering of the rotation algorithm: fold, ITER micro-rotations, unfold.
  task automatic model(input int ang, output int xo, output int yo, output bit rerr);
    int at[12] = '{3217, 1899, 1003, 509, 256, 128, 64, 32, 16, 8, 4, 2};
    int x, y, z, xn;
    bit flip;
    rerr = (ang > 12868) || (ang < -12868);
    flip = 1'b1;
    if (ang > 6434) z = ang - 12868;
    else if (ang < -6434) z = ang + 12868;
    else begin z = ang; flip = 1'b0; end
    x = 4096;
    y = 0;
    for (int i = 0; i < ITER; i++) begin
      if (z >= 0) begin
        xn = x - (y >>> i); y = y + (x >>> i); z = z - at[i];
      end else begin
        xn = x + (y >>> i); y = y - (x >>> i); z = z + at[i];
      end
      x = xn;
    end
    xo = flip ? -x : x;
    yo = flip ? -y : y;
  endtask

  task automatic start_now(input int ang);
    start = 1'b1;
    angle_in = ang[DW-1:0];
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic start_op(input int ang);
    @(negedge clk);
    start_now(ang);
  endtask

  // Called at the first negedge after the accepting edge; returns at the new_data cycle.
  task automatic wait_done(input int extra_at, input int extra_ang, output int n, output int bcnt);
    n = 1;
    bcnt = 0;
    while (!new_data && n <= 40) begin
      if (busy) bcnt++;
      if (n == extra_at) begin
        start = 1'b1;
        angle_in = extra_ang[DW-1:0];
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int ang, input bit tol);
    int xe, ye, xr, yr, dx, dy;
    bit re;
    real a;
    model(ang, xe, ye, re);
    check({tag, "_x"}, 32'(x_out), 32'(sm_of(xe)));
    check({tag, "_y"}, 32'(y_out), 32'(sm_of(ye)));
    check({tag, "_rerr"}, 32'(range_err), 32'(re));
    if (tol) begin
      a  = ang / 4096.0;
      xr = $rtoi($floor(4096.0 / 0.607253 * $cos(a) + 0.5));
      yr = $rtoi($floor(4096.0 / 0.607253 * $sin(a) + 0.5));
      dx = int_of_sm(x_out) - xr;
      dy = int_of_sm(y_out) - yr;
      check({tag, "_xtol"}, 32'(dx >= -4 && dx <= 4), 32'd1);
      check({tag, "_ytol"}, 32'(dy >= -4 && dy <= 4), 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input int ang, input bit tol);
    int n, bc, xe, ye;
    bit re;
    start_op(ang);
    wait_done(0, 0, n, bc);
    check({tag, "_lat"}, 32'(n), 32'd15);
    check({tag, "_busy"}, 32'(bc), 32'd14);
    check_result(tag, ang, tol);
    @(negedge clk);
    model(ang, xe, ye, re);
    check({tag, "_pulse"}, 32'(new_data), 32'd0);
    check({tag, "_hold"}, 32'(x_out), 32'(sm_of(xe)));
  endtask

  initial begin
    int n, bc, pulses, ang;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_nd", 32'(new_data), 32'd0);
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_y", 32'(y_out), 32'd0);
    check("rst_rerr", 32'(range_err), 32'd0);
    rst = 1'b0;

    run_op("zero", 0, 1'b1);
    run_op("pi2", 6434, 1'b1);
    run_op("mpi4", -3217, 1'b1);
    run_op("pi", 12868, 1'b1);
    run_op("mpi", -12868, 1'b1);
    run_op("over", 13000, 1'b0);
    check("over_flag", 32'(range_err), 32'd1);
    run_op("under", -13000, 1'b0);

    // Start pulsed mid-operation must be ignored.
    start_op(3217);
    wait_done(3, -6000, n, bc);
    check("ign_lat", 32'(n), 32'd15);
    check_result("ign", 3217, 1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (new_data) pulses++;
    end
    check("ign_extra", 32'(pulses), 32'd0);

    // Back-to-back start accepted in the DONE cycle.
    start_op(1000);
    wait_done(0, 0, n, bc);
    check("b2b1_lat", 32'(n), 32'd15);
    check_result("b2b1", 1000, 1'b1);
    start_now(-9000);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_pulse", 32'(new_data), 32'd0);
    wait_done(0, 0, n, bc);
    check("b2b2_lat", 32'(n), 32'd15);
    check_result("b2b2", -9000, 1'b1);

    // Abort during rotation.
    start_op(5000);
    repeat (5) @(negedge clk);
    rst_step = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_nd", 32'(new_data), 32'd0);
    check("abort_x", 32'(x_out), 32'd0);
    check("abort_y", 32'(y_out), 32'd0);
    @(negedge clk);
    rst_step = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (new_data) pulses++;
    end
    check("abort_nopulse", 32'(pulses), 32'd0);
    run_op("after_abort", 5000, 1'b1);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(3, 0) != 0) ang = int'($urandom_range(26000, 0)) - 13000;
      else ang = int'({{12{1'b0}}, 20'($urandom)}) - (1 << 19);
      run_op("rnd", ang, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
